// File: rtl/mem_burst_reader.sv
// Burst read initiator: walks a read-only memory port from start_addr for
// `length` words and streams the captured words over a valid/ready interface.
module mem_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oenable,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; out_data/out_last stay stable while valid & !ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    mem_oenable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d     = S_READ;
            addr_d      = start_addr;
            remaining_d = length;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_READ: begin
        // A read is only issued when the output register is free or emptying.
        mem_oenable = !valid_q || out_ready;
        if (mem_oenable) begin
          data_d      = mem_data;
          valid_d     = 1'b1;
          last_d      = (remaining_q == LEN_WIDTH'(1));
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: ROM model, expected-word and expected-address
// queues built from the burst rules, table vectors plus random bursts.
module tb_mem_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic        mem_oenable;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  rom [65536];
  logic [7:0]  junk;
  logic [8:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];

  mem_burst_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_oenable(mem_oenable),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Floating bus modelled as changing junk so any stray capture is visible.
  assign mem_data = mem_oenable ? rom[mem_addr] : junk;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) junk = 8'($urandom);

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void flag(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none at %0t", nm, $time);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_oenable) begin
        if (exp_addr_q.size() == 0) flag("unexpected_read");
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag("unexpected_word");
        else check("word_last_data", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
      end
      if (out_valid && !out_ready) check("oen_under_stall", 32'(mem_oenable), 0);
      if (!busy) check("oen_while_idle", 32'(mem_oenable), 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic pick_ready(int stall, int cyc);
    if (stall < 0) return !(cyc >= 3 && cyc <= 5);
    if (stall == 0) return 1'b1;
    return ($urandom_range(99) >= 32'(stall));
  endfunction

  // stall: 0 = always ready, >0 = percent of cycles with ready low,
  // -1 = ready low in cycles 3..5 only. exp_done < 0 skips the timing check.
  task automatic run_burst(input logic [15:0] a, input logic [15:0] l, input int stall,
                           input int exp_done, input bit poke);
    int cyc;
    int bound;
    bit got;
    bit saw_busy;
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] ad;
      ad = a + 16'(i);
      exp_addr_q.push_back(ad);
      exp_q.push_back({(i == int'(l) - 1), rom[ad]});
    end
    bound = 10 * int'(l) + 40;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = l;
    out_ready = pick_ready(stall, 0);
    cyc = 0; got = 1'b0; saw_busy = 1'b0;
    while (cyc < bound) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (stall < 0 && cyc == 3) begin
        check("stall_data", 32'(out_data), 32'(rom[a + 16'd1]));
        check("stall_addr", 32'(mem_addr), 32'(a + 16'd2));
        check("stall_valid", 32'(out_valid), 1);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        start_addr = a ^ 16'h5555;
        length     = l + 16'd3;
      end
      out_ready = pick_ready(stall, cyc);
    end
    check("done_seen", 32'(got), 1);
    if (exp_done >= 0) check("done_cycle", 32'(cyc), 32'(exp_done));
    check("words_left", 32'(exp_q.size()), 0);
    check("reads_left", 32'(exp_addr_q.size()), 0);
    if (l == 0) check("busy_len0", 32'(saw_busy), 0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_one_pulse", 32'(done), 0);
    check("idle_after", 32'(busy), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_last"}, 32'(out_last), 0);
    check({tag, "_oen"}, 32'(mem_oenable), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] len;
    int          stall;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{16'h0010, 16'd4, 0, 6};    // basic burst, full throughput
    vecs[1] = '{16'h0010, 16'd4, -1, 9};   // ready low cycles 3..5
    vecs[2] = '{16'hFFFE, 16'd4, 0, 6};    // address wraps inside burst
    vecs[3] = '{16'h1234, 16'd0, 0, 1};    // empty burst
    vecs[4] = '{16'h0020, 16'd1, 0, 3};    // single word
    vecs[5] = '{16'h0400, 16'd7, 50, -1};  // heavy random backpressure

    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[16'h0010] = 8'hA0; rom[16'h0011] = 8'hA1;
    rom[16'h0012] = 8'hA2; rom[16'h0013] = 8'hA3;

    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_burst(vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].exp_done, 1'b0);

    // Second start mid-burst must not disturb the running burst.
    run_burst(16'h0010, 16'd4, 0, 6, 1'b1);

    // Reset in cycle 3 of a length-8 burst aborts it without a done pulse.
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(16'h0100 + 16'(i));
      exp_q.push_back({(i == 7), rom[16'h0100 + 16'(i)]});
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = 16'h0100; length = 16'd8; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check_all_zero("abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    run_burst(16'h0010, 16'd4, 0, 6, 1'b0);

    // Random bursts against the queue model.
    for (int t = 0; t < 14; t++) begin
      logic [15:0] a;
      logic [15:0] l;
      int st;
      a  = 16'($urandom);
      if (t % 4 == 0) a = 16'hFFF0 + 16'($urandom_range(15));
      l  = 16'($urandom_range(0, 24));
      st = (t % 3 == 0) ? 0 : int'($urandom_range(5, 60));
      run_burst(a, l, st, (st == 0) ? ((l == 0) ? 1 : int'(l) + 2) : -1, (t % 5 == 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
